// File: rtl/data_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arb_pkg
//  Description : Shared types and constants for the DataMemory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arb_pkg;

  // Default widths of the DataMemory interface
  localparam int c_ADDR_W = 16;
  localparam int c_DATA_W = 16;

  // Requester indices: CPU load/store stage and DMA/program loader
  localparam logic c_PORT_CPU = 1'b0;
  localparam logic c_PORT_DMA = 1'b1;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage : data_mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin picker. ptr names the favoured port on a
//                tie; next_ptr favours the port that did not win.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       next_ptr
);

  logic w_pick_dma;
  logic w_pick_cpu;

  // DMA wins when it is alone or when the pointer favours it on a tie
  always_comb begin
    w_pick_dma = enable & req[c_PORT_DMA] & (~req[c_PORT_CPU] | ptr);
    w_pick_cpu = enable & req[c_PORT_CPU] & ~w_pick_dma;
    grant      = 2'b00;
    grant[c_PORT_DMA] = w_pick_dma;
    grant[c_PORT_CPU] = w_pick_cpu;
    next_ptr   = ptr;
    if (w_pick_cpu) begin
      next_ptr = c_PORT_DMA;
    end else if (w_pick_dma) begin
      next_ptr = c_PORT_CPU;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Shares the single-port DataMemory between the CPU (port 0)
//                and the DMA/loader (port 1). Each access runs
//                IDLE -> ACCESS (one memory cycle) -> RESP (one-cycle ack).
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W      = c_ADDR_W,
  parameter int DATA_W      = c_DATA_W,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] ReadData
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          w_grant;
  logic                w_next_ptr;
  logic                w_arb_ptr;
  logic                w_arb_en;
  logic                r_ptr;
  logic                r_gnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  // Fixed priority is round-robin with the pointer pinned on the CPU port
  assign w_arb_ptr = (ROUND_ROBIN != 0) ? r_ptr : c_PORT_CPU;
  assign w_arb_en  = (r_state == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .req      ({req1, req0}),
    .ptr      (w_arb_ptr),
    .enable   (w_arb_en),
    .grant    (w_grant),
    .next_ptr (w_next_ptr)
  );

  // State register; reset drops straight back to IDLE, abandoning any access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus memory-side drive and acks, all decoded from the state
  always_comb begin
    w_state_nxt = r_state;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    Address     = '0;
    WriteData   = '0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        MemWrite    = r_we;
        MemRead     = ~r_we;
        Address     = r_addr;
        WriteData   = r_wdata;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        ack0        = (r_gnt == c_PORT_CPU);
        ack1        = (r_gnt == c_PORT_DMA);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture the winner's request at grant so later changes cannot disturb it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr   <= c_PORT_CPU;
      r_gnt   <= c_PORT_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (|w_grant) begin
      r_ptr   <= w_next_ptr;
      r_gnt   <= w_grant[c_PORT_DMA];
      r_we    <= w_grant[c_PORT_DMA] ? we1    : we0;
      r_addr  <= w_grant[c_PORT_DMA] ? addr1  : addr0;
      r_wdata <= w_grant[c_PORT_DMA] ? wdata1 : wdata0;
    end
  end

  // Read data lands in the granted port's register; the other one holds
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if ((r_state == ST_ACCESS) && !r_we) begin
      if (r_gnt == c_PORT_DMA) begin
        r_rdata1 <= ReadData;
      end else begin
        r_rdata0 <= ReadData;
      end
    end
  end

  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule : data_mem_arbiter
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Self-checking bench. Two arbiters (round-robin and fixed
//                priority) share the stimulus; each has its own memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic        a_ack0, a_ack1, a_MemWrite, a_MemRead;
  logic [15:0] a_rdata0, a_rdata1, a_Address, a_WriteData, a_ReadData;
  logic        b_ack0, b_ack1, b_MemWrite, b_MemRead;
  logic [15:0] b_rdata0, b_rdata1, b_Address, b_WriteData, b_ReadData;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] ref_mem [256];

  typedef struct packed {
    logic        port;
    logic        is_read;
    logic [15:0] rdata;
  } exp_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic rr_last  = 1'b1;

  always #5 clock = ~clock;

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .ROUND_ROBIN(1)) dut_rr (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(a_ack0), .ack1(a_ack1), .rdata0(a_rdata0), .rdata1(a_rdata1),
    .Address(a_Address), .WriteData(a_WriteData),
    .MemWrite(a_MemWrite), .MemRead(a_MemRead), .ReadData(a_ReadData)
  );

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .Address(b_Address), .WriteData(b_WriteData),
    .MemWrite(b_MemWrite), .MemRead(b_MemRead), .ReadData(b_ReadData)
  );

  // DataMemory models: combinational read, write on rising edge, 256 words
  assign a_ReadData = a_MemRead ? mem_a[a_Address[7:0]] : 16'h0000;
  assign b_ReadData = b_MemRead ? mem_b[b_Address[7:0]] : 16'h0000;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= {i[7:0], i[7:0]};
        mem_b[i] <= {i[7:0], i[7:0]};
      end
    end else begin
      if (a_MemWrite) mem_a[a_Address[7:0]] <= a_WriteData;
      if (b_MemWrite) mem_b[b_Address[7:0]] <= b_WriteData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard pop for the round-robin instance
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (a_ack0 || a_ack1)) begin
      chk("a_ack_overlap", 32'(a_ack0 & a_ack1), 32'd0);
      chk("a_ack_expected", 32'(sb_a.size() > 0), 32'd1);
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        chk("a_ack_port", 32'(a_ack1), 32'(e.port));
        if (e.is_read) chk("a_rdata", 32'(e.port ? a_rdata1 : a_rdata0), 32'(e.rdata));
      end
    end
  end

  // Scoreboard pop for the fixed-priority instance
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (b_ack0 || b_ack1)) begin
      chk("b_ack_overlap", 32'(b_ack0 & b_ack1), 32'd0);
      chk("b_ack_expected", 32'(sb_b.size() > 0), 32'd1);
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        chk("b_ack_port", 32'(b_ack1), 32'(e.port));
        if (e.is_read) chk("b_rdata", 32'(e.port ? b_rdata1 : b_rdata0), 32'(e.rdata));
      end
    end
  end

  task automatic push_both(input logic port, input logic is_read, input logic [15:0] rdata);
    exp_t e;
    e.port = port; e.is_read = is_read; e.rdata = rdata;
    sb_a.push_back(e);
    sb_b.push_back(e);
  endtask

  // One uncontended access with latency and memory-side checks
  task automatic do_access(input vec_t v);
    logic [15:0] other_before;
    @(negedge clock);
    other_before = v.port ? a_rdata0 : a_rdata1;
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    push_both(v.port, !v.we, v.exp_rdata);
    if (v.we) ref_mem[v.addr[7:0]] = v.wdata;
    rr_last = v.port;
    @(negedge clock);
    chk("access_memwrite", 32'(a_MemWrite), 32'(v.we));
    chk("access_memread", 32'(a_MemRead), 32'(!v.we));
    chk("access_addr", 32'(a_Address), 32'(v.addr));
    if (v.we) chk("access_wdata", 32'(a_WriteData), 32'(v.wdata));
    @(negedge clock);
    chk("resp_ack", 32'(v.port ? a_ack1 : a_ack0), 32'd1);
    chk("resp_mem_idle", 32'({a_MemWrite, a_MemRead}), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    chk("ack_one_cycle", 32'({a_ack0, a_ack1}), 32'd0);
    chk("other_rdata_held", 32'(v.port ? a_rdata0 : a_rdata1), 32'(other_before));
  endtask

  vec_t vecs[7];

  initial begin
    logic pa;
    vec_t v;
    for (int i = 0; i < 256; i++) ref_mem[i] = {i[7:0], i[7:0]};

    vecs[0] = '{port: 1'b0, we: 1'b1, addr: 16'd12,   wdata: 16'h0012, exp_rdata: 16'h0000};
    vecs[1] = '{port: 1'b0, we: 1'b0, addr: 16'd12,   wdata: 16'h0000, exp_rdata: 16'h0012};
    vecs[2] = '{port: 1'b1, we: 1'b1, addr: 16'hFFFF, wdata: 16'hBEEF, exp_rdata: 16'h0000};
    vecs[3] = '{port: 1'b0, we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, exp_rdata: 16'hBEEF};
    vecs[4] = '{port: 1'b1, we: 1'b0, addr: 16'd12,   wdata: 16'h0000, exp_rdata: 16'h0012};
    vecs[5] = '{port: 1'b0, we: 1'b1, addr: 16'h0000, wdata: 16'hA5A5, exp_rdata: 16'h0000};
    vecs[6] = '{port: 1'b1, we: 1'b0, addr: 16'h0000, wdata: 16'h0000, exp_rdata: 16'hA5A5};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_ack", 32'({a_ack0, a_ack1}), 32'd0);
    chk("rst_rdata0", 32'(a_rdata0), 32'd0);
    chk("rst_rdata1", 32'(a_rdata1), 32'd0);
    chk("rst_addr", 32'(a_Address), 32'd0);
    chk("rst_wdata", 32'(a_WriteData), 32'd0);
    chk("rst_mem_ctl", 32'({a_MemWrite, a_MemRead}), 32'd0);
    mem_init = 1'b0;
    reset = 1'b0;

    // Table-driven single accesses
    for (int i = 0; i < 7; i++) do_access(vecs[i]);

    // Contention with requests held across acks: four grants expected
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd4;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      pa = ~rr_last;
      rr_last = pa;
      e.port = pa; e.is_read = 1'b1; e.rdata = pa ? ref_mem[4] : ref_mem[3];
      sb_a.push_back(e);
      e.port = 1'b0; e.is_read = 1'b1; e.rdata = ref_mem[3];
      sb_b.push_back(e);
    end
    repeat (10) @(posedge clock);
    @(negedge clock);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clock);
    chk("rr_contention_drained", 32'(sb_a.size()), 32'd0);
    chk("fp_contention_drained", 32'(sb_b.size()), 32'd0);

    // req1 dropped during ACCESS; request fields changed after grant
    @(negedge clock);
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h1234;
    push_both(1'b1, 1'b0, 16'h0000);
    ref_mem[8'h20] = 16'h1234;
    rr_last = 1'b1;
    @(negedge clock);
    req1 = 1'b0; addr1 = 16'h0055; wdata1 = 16'hDEAD;
    chk("drop_memwrite", 32'(a_MemWrite), 32'd1);
    chk("drop_addr_latched", 32'(a_Address), 32'h0020);
    @(negedge clock);
    chk("drop_ack1", 32'(a_ack1), 32'd1);
    v = '{port: 1'b0, we: 1'b0, addr: 16'h0020, wdata: 16'h0000, exp_rdata: ref_mem[8'h20]};
    do_access(v);
    v = '{port: 1'b1, we: 1'b0, addr: 16'h0055, wdata: 16'h0000, exp_rdata: ref_mem[8'h55]};
    do_access(v);

    // Reset asserted in ACCESS: Mem* drop at once, no ack, next request served
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h7777;
    @(negedge clock);
    chk("pre_reset_memwrite", 32'(a_MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_mem_ctl", 32'({a_MemWrite, a_MemRead}), 32'd0);
    chk("reset_addr", 32'(a_Address), 32'd0);
    req0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    rr_last = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("reset_no_ack", 32'({a_ack0, a_ack1}), 32'd0);
    end
    do_access(vecs[1]);

    repeat (2) @(negedge clock);
    chk("a_scoreboard_empty", 32'(sb_a.size()), 32'd0);
    chk("b_scoreboard_empty", 32'(sb_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_data_mem_arbiter
`default_nettype wire
